// File: rtl/issue_scoreboard.sv
// In-order N-wide issue scoreboard: selects the longest issuable prefix of the
// oldest queued slots and tracks per-GPR pending writes cleared by writeback.
module issue_scoreboard #(
  parameter int ISSUE_W   = 2,
  parameter int WB_W      = 2,
  parameter int ALU_N     = 2,
  parameter int WB_BYPASS = 1,
  localparam int CNT_W    = $clog2(ISSUE_W + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ISSUE_W-1:0]       slot_valid,
  input  logic [ISSUE_W-1:0][4:0]  slot_src_a,
  input  logic [ISSUE_W-1:0][4:0]  slot_src_b,
  input  logic [ISSUE_W-1:0]       slot_src_a_en,
  input  logic [ISSUE_W-1:0]       slot_src_b_en,
  input  logic [ISSUE_W-1:0][4:0]  slot_dst,
  input  logic [ISSUE_W-1:0]       slot_dst_en,
  input  logic [ISSUE_W-1:0][2:0]  slot_unit,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [WB_W-1:0]          wb_en,
  input  logic [WB_W-1:0][4:0]     wb_reg,
  output logic [ISSUE_W-1:0]       issue_grant,
  output logic [CNT_W-1:0]         issue_cnt,
  output logic [31:0]              pending,
  output logic [5:0]               busy_cnt
);

  typedef enum logic [2:0] {
    U_ALU    = 3'd0,
    U_MEM    = 3'd1,
    U_BRANCH = 3'd2,
    U_HILO   = 3'd3,
    U_MLT    = 3'd4,
    U_DIV    = 3'd5,
    U_COP0   = 3'd6,
    U_NONE   = 3'd7
  } unit_e;

  logic [31:0]        pending_q, pending_d;
  logic [5:0]         busy_q, busy_d;
  logic [31:0]        wb_hit;
  logic [31:0]        pend_eff;
  logic [31:0]        wr_mask;
  logic [31:0]        req;
  logic [7:0]         class_used;
  logic               ok, blocked, br_pend, mul_seen;
  int                 n_grant, alu_cnt;
  logic [ISSUE_W-1:0] grant;

  always_comb begin : wb_decode
    wb_hit = '0;
    for (int k = 0; k < WB_W; k++) begin
      if (wb_en[k]) wb_hit[wb_reg[k]] = 1'b1;
    end
    wb_hit[0] = 1'b0;
  end

  assign pend_eff = (WB_BYPASS != 0) ? (pending_q & ~wb_hit) : pending_q;

  // A branch is held back until its delay slot proves issuable; the pair then
  // advances the grant count by two, otherwise the group ends before the branch.
  always_comb begin : issue_select
    n_grant    = 0;
    alu_cnt    = 0;
    class_used = '0;
    mul_seen   = 1'b0;
    wr_mask    = '0;
    blocked    = 1'b0;
    br_pend    = 1'b0;
    ok         = 1'b0;
    req        = '0;
    for (int j = 0; j < ISSUE_W; j++) begin
      req = '0;
      if (slot_src_a_en[j]) req[slot_src_a[j]] = 1'b1;
      if (slot_src_b_en[j]) req[slot_src_b[j]] = 1'b1;
      if (slot_dst_en[j])   req[slot_dst[j]]   = 1'b1;
      req[0] = 1'b0;
      ok = slot_valid[j] && !blocked && ((req & (pend_eff | wr_mask)) == '0);
      if (slot_unit[j] == U_ALU) begin
        if (alu_cnt >= ALU_N) ok = 1'b0;
      end else if (slot_unit[j] != U_NONE) begin
        if (class_used[slot_unit[j]]) ok = 1'b0;
      end
      if (slot_unit[j] == U_HILO && mul_seen) ok = 1'b0;
      if (slot_unit[j] == U_BRANCH && (j == ISSUE_W - 1 || br_pend)) ok = 1'b0;
      if (ok) begin
        if (slot_unit[j] == U_ALU) alu_cnt = alu_cnt + 1;
        else class_used[slot_unit[j]] = 1'b1;
        if (slot_unit[j] == U_MLT || slot_unit[j] == U_DIV) mul_seen = 1'b1;
        if (slot_dst_en[j] && slot_dst[j] != 5'd0) wr_mask[slot_dst[j]] = 1'b1;
        if (br_pend) n_grant = n_grant + 2;
        else if (slot_unit[j] != U_BRANCH) n_grant = n_grant + 1;
        br_pend = (slot_unit[j] == U_BRANCH);
      end else begin
        blocked = 1'b1;
        br_pend = 1'b0;
      end
    end
    if (reset || stall || flush) n_grant = 0;
  end

  always_comb begin : grant_mask
    grant = '0;
    for (int j = 0; j < ISSUE_W; j++) begin
      grant[j] = (j < n_grant);
    end
  end

  // Sets are applied after clears so a younger writer keeps its register busy.
  always_comb begin : next_pending
    pending_d = pending_q & ~wb_hit;
    for (int j = 0; j < ISSUE_W; j++) begin
      if (grant[j] && slot_dst_en[j]) pending_d[slot_dst[j]] = 1'b1;
    end
    pending_d[0] = 1'b0;
    if (flush) pending_d = '0;
    busy_d = 6'($countones(pending_d));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      busy_q    <= '0;
    end else begin
      pending_q <= pending_d;
      busy_q    <= busy_d;
    end
  end

  assign issue_grant = grant;
  assign issue_cnt   = CNT_W'(n_grant);
  assign pending     = pending_q;
  assign busy_cnt    = busy_q;

endmodule
